// File: rtl/uart_pkg.sv
// Shared UART encodings and helpers used by both the RX and TX controllers.
package uart_pkg;

    localparam int UART_SAMPLES_PER_BIT = 5;

    typedef enum logic {
        STOP_ONE = 1'b0,
        STOP_TWO = 1'b1
    } uart_stop_e;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } uart_parity_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } uart_rx_state_e;

    function automatic logic majority3(input logic [2:0] w);
        return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    endfunction

    // Keeps the low (len+1) bits; len is "data bits minus one".
    function automatic logic [7:0] data_mask(input logic [2:0] len);
        logic [7:0] mask;
        for (int i = 0; i < 8; i++) begin
            mask[i] = (i <= int'(len));
        end
        return mask;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Synchroniser for the asynchronous serial input followed by a 3-sample
// majority filter that advances only on sampling ticks.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic io_mainClk,
    input  logic resetCtrl_systemReset,
    input  logic tick_i,
    input  logic rxd_i,
    output logic filtered_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [2:0]             window_q;
    logic [2:0]             window_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = rxd_i;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        window_d = window_q;
        if (tick_i) begin
            window_d = {window_q[1:0], sync_q[SYNC_STAGES-1]};
        end
    end

    // Idle line is high, so everything resets to 1 to avoid a false start.
    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            sync_q   <= '1;
            window_q <= 3'b111;
        end else begin
            sync_q   <= sync_d;
            window_q <= window_d;
        end
    end

    assign filtered_o = majority3(window_q);

endmodule

// File: rtl/uart_ctrl_rx.sv
// UART receive controller: start detection, data/parity/stop deserialisation
// and break detection, all timed by the shared oversampling tick.
module uart_ctrl_rx
    import uart_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = UART_SAMPLES_PER_BIT,
    parameter int SYNC_STAGES     = 2,
    parameter int BREAK_TICKS     = 100
) (
    input  logic       io_mainClk,
    input  logic       resetCtrl_systemReset,
    input  logic [2:0] io_configFrame_dataLength,
    input  logic       io_configFrame_stop,
    input  logic [1:0] io_configFrame_parity,
    input  logic       io_samplingTick,
    input  logic       io_rxd,
    output logic       io_read_valid,
    output logic [7:0] io_read_payload,
    output logic       io_error,
    output logic       io_break
);

    localparam logic [2:0] TIMER_RELOAD = 3'(SAMPLES_PER_BIT - 1);
    localparam logic [2:0] TIMER_HALF   = 3'(SAMPLES_PER_BIT / 2);
    localparam int         BREAK_W      = $clog2(BREAK_TICKS + 1);
    localparam logic [BREAK_W-1:0] BREAK_MAX = BREAK_W'(BREAK_TICKS);

    logic filtered;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .io_mainClk           (io_mainClk),
        .resetCtrl_systemReset(resetCtrl_systemReset),
        .tick_i               (io_samplingTick),
        .rxd_i                (io_rxd),
        .filtered_o           (filtered)
    );

    uart_rx_state_e     state_q, state_d;
    logic [2:0]         timer_q, timer_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_acc_q, parity_acc_d;
    logic               parity_err_q, parity_err_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;
    logic [7:0]         payload_q, payload_d;
    logic [BREAK_W-1:0] break_cnt_q, break_cnt_d;
    logic               bit_tick;

    assign bit_tick = io_samplingTick && (timer_q == 3'd0);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_acc_d = parity_acc_q;
        parity_err_d = parity_err_q;
        valid_d      = 1'b0;
        error_d      = 1'b0;
        payload_d    = payload_q;

        if (io_samplingTick) begin
            timer_d = (timer_q == 3'd0) ? TIMER_RELOAD : timer_q - 3'd1;
        end

        case (state_q)
            RX_IDLE: begin
                // Half a bit delay puts subsequent bit ticks near mid-bit.
                if (io_samplingTick && !filtered) begin
                    state_d = RX_START;
                    timer_d = TIMER_HALF;
                end
            end
            RX_START: begin
                if (bit_tick) begin
                    if (filtered) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d      = RX_DATA;
                        bit_cnt_d    = 3'd0;
                        parity_acc_d = (io_configFrame_parity == PARITY_ODD);
                        parity_err_d = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    shift_d[bit_cnt_q] = filtered;
                    parity_acc_d       = parity_acc_q ^ filtered;
                    if (bit_cnt_q == io_configFrame_dataLength) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (io_configFrame_parity == PARITY_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (bit_tick) begin
                    parity_err_d = (filtered != parity_acc_q);
                    state_d      = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_tick) begin
                    if (!filtered) begin
                        error_d = 1'b1;
                        state_d = RX_IDLE;
                    end else if (bit_cnt_q == {2'b00, io_configFrame_stop}) begin
                        state_d = RX_IDLE;
                        if (parity_err_q) begin
                            error_d = 1'b1;
                        end else begin
                            valid_d   = 1'b1;
                            payload_d = shift_q & data_mask(io_configFrame_dataLength);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Break detector runs independently of the frame FSM.
    always_comb begin
        break_cnt_d = break_cnt_q;
        if (io_samplingTick) begin
            if (filtered) begin
                break_cnt_d = '0;
            end else if (break_cnt_q != BREAK_MAX) begin
                break_cnt_d = break_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            state_q      <= RX_IDLE;
            timer_q      <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_acc_q <= 1'b0;
            parity_err_q <= 1'b0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            payload_q    <= 8'd0;
            break_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_acc_q <= parity_acc_d;
            parity_err_q <= parity_err_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            payload_q    <= payload_d;
            break_cnt_q  <= break_cnt_d;
        end
    end

    assign io_read_valid   = valid_q;
    assign io_error        = error_q;
    assign io_read_payload = payload_q;
    assign io_break        = (break_cnt_q == BREAK_MAX);

endmodule

// File: tb/tb_uart_ctrl_rx.sv
// Directed bench for uart_ctrl_rx: frames are driven bit by bit on io_rxd and
// the resulting valid/error/break behaviour is compared with hand-derived values.
module tb_uart_ctrl_rx;
    import uart_pkg::*;

    localparam int SPB = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] data_len = 3'd7;
    logic       stop_cfg = 1'b0;
    logic [1:0] par_cfg = 2'd0;
    logic       tick = 1'b1;
    logic       rxd = 1'b1;
    logic       valid;
    logic       err;
    logic       brk;
    logic [7:0] payload;

    int tick_div = 1;
    int tick_ctr = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    int start_cyc = 0;
    int v0 = 0;
    int e0 = 0;
    int s0 = 0;
    int errors = 0;
    int checks = 0;

    uart_ctrl_rx #(
        .SAMPLES_PER_BIT(SPB),
        .SYNC_STAGES    (2),
        .BREAK_TICKS    (100)
    ) dut (
        .io_mainClk               (clk),
        .resetCtrl_systemReset    (rst),
        .io_configFrame_dataLength(data_len),
        .io_configFrame_stop      (stop_cfg),
        .io_configFrame_parity    (par_cfg),
        .io_samplingTick          (tick),
        .io_rxd                   (rxd),
        .io_read_valid            (valid),
        .io_read_payload          (payload),
        .io_error                 (err),
        .io_break                 (brk)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_ctr = (tick_ctr + 1 >= tick_div) ? 0 : tick_ctr + 1;
        tick     = (tick_ctr == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) valid_cnt++;
            if (err) error_cnt++;
            if (dut.state_q == RX_START) start_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        v0 = valid_cnt;
        e0 = error_cnt;
        s0 = start_cyc;
    endtask

    // Bits go out LSB first, each held for one bit period of ticks.
    task automatic send_bits(input string name, input logic [15:0] bits, input int n);
        $display("tx %s: %0d bits 0x%0h", name, n, bits);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (SPB * tick_div) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    initial begin
        idle(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_error", 32'(err), 32'd0);
        check("rst_break", 32'(brk), 32'd0);
        check("rst_payload", 32'(payload), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(RX_IDLE));
        rst = 1'b0;
        idle(10);

        // 8N1, 0xA5
        data_len = 3'd7; par_cfg = 2'd0; stop_cfg = 1'b0;
        mark();
        send_bits("8N1_A5", {1'b1, 8'hA5, 1'b0}, 10);
        idle(10);
        check("8n1_valid", 32'(valid_cnt - v0), 32'd1);
        check("8n1_error", 32'(error_cnt - e0), 32'd0);
        check("8n1_payload", 32'(payload), 32'hA5);
        check("8n1_idle", 32'(dut.state_q), 32'(RX_IDLE));

        // 7E1, 0x35 has four ones so even parity bit is 0
        data_len = 3'd6; par_cfg = 2'd1;
        mark();
        send_bits("7E1_35_ok", {1'b1, 1'b0, 7'h35, 1'b0}, 10);
        idle(10);
        check("7e1_valid", 32'(valid_cnt - v0), 32'd1);
        check("7e1_error", 32'(error_cnt - e0), 32'd0);
        check("7e1_payload", 32'(payload), 32'h35);
        mark();
        send_bits("7E1_35_badpar", {1'b1, 1'b1, 7'h35, 1'b0}, 10);
        idle(10);
        check("7e1_bad_valid", 32'(valid_cnt - v0), 32'd0);
        check("7e1_bad_error", 32'(error_cnt - e0), 32'd1);
        check("7e1_bad_hold", 32'(payload), 32'h35);

        // 5O2, 0x13 has three ones so odd parity bit is 0
        data_len = 3'd4; par_cfg = 2'd2; stop_cfg = 1'b1;
        mark();
        send_bits("5O2_13_ok", {1'b1, 1'b1, 1'b0, 5'h13, 1'b0}, 9);
        idle(10);
        check("5o2_valid", 32'(valid_cnt - v0), 32'd1);
        check("5o2_error", 32'(error_cnt - e0), 32'd0);
        check("5o2_payload", 32'(payload), 32'h13);
        mark();
        send_bits("5O2_13_badstop", {1'b0, 1'b1, 1'b0, 5'h13, 1'b0}, 9);
        idle(20);
        check("5o2_stop_valid", 32'(valid_cnt - v0), 32'd0);
        check("5o2_stop_error", 32'(error_cnt - e0), 32'd1);

        // Glitches on an idle 8N1 line
        data_len = 3'd7; par_cfg = 2'd0; stop_cfg = 1'b0;
        mark();
        $display("tx glitch: 2 ticks low");
        rxd = 1'b0; idle(2); rxd = 1'b1;
        idle(20);
        check("glitch2_start", 32'(start_cyc > s0), 32'd1);
        check("glitch2_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch2_error", 32'(error_cnt - e0), 32'd0);
        check("glitch2_idle", 32'(dut.state_q), 32'(RX_IDLE));
        mark();
        $display("tx glitch: 1 tick low");
        rxd = 1'b0; idle(1); rxd = 1'b1;
        idle(20);
        check("glitch1_start", 32'(start_cyc - s0), 32'd0);
        check("glitch1_error", 32'(error_cnt - e0), 32'd0);

        // Break: 120 ticks low
        mark();
        $display("tx break: 120 ticks low");
        rxd = 1'b0;
        idle(60);
        check("brk_error", 32'(error_cnt - e0), 32'd1);
        check("brk_valid", 32'(valid_cnt - v0), 32'd0);
        idle(30);
        check("brk_early", 32'(brk), 32'd0);
        idle(25);
        check("brk_set", 32'(brk), 32'd1);
        idle(5);
        rxd = 1'b1;
        idle(2);
        check("brk_held", 32'(brk), 32'd1);
        idle(8);
        check("brk_clear", 32'(brk), 32'd0);
        idle(120);

        // Reset in the middle of a 0xFF frame
        mark();
        $display("tx 8N1_FF: reset during data");
        rxd = 1'b0; idle(SPB);
        rxd = 1'b1; idle(SPB * 3);
        check("mid_in_data", 32'(dut.state_q), 32'(RX_DATA));
        rst = 1'b1;
        idle(1);
        check("mid_rst_idle", 32'(dut.state_q), 32'(RX_IDLE));
        idle(2);
        rst = 1'b0;
        idle(SPB * 8);
        check("mid_rst_valid", 32'(valid_cnt - v0), 32'd0);
        check("mid_rst_error", 32'(error_cnt - e0), 32'd0);

        // Sparse ticks: one every third cycle
        tick_div = 3;
        idle(6);
        mark();
        send_bits("8N1_00_slow", {1'b1, 8'h00, 1'b0}, 10);
        idle(40);
        check("slow00_valid", 32'(valid_cnt - v0), 32'd1);
        check("slow00_error", 32'(error_cnt - e0), 32'd0);
        check("slow00_payload", 32'(payload), 32'h00);
        mark();
        send_bits("8N1_5A_slow", {1'b1, 8'h5A, 1'b0}, 10);
        idle(40);
        check("slow5a_valid", 32'(valid_cnt - v0), 32'd1);
        check("slow5a_payload", 32'(payload), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
